// File: rtl/alarm_set_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_set_controller
//  Purpose  : Alarm entry sequencer (hour/minute/second) plus ring, snooze
//             and auto-stop control. Optional snooze: ALARM_SNOOZE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_set_controller #(
`ifdef ALARM_SNOOZE_EN
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3,
`endif
   parameter int RING_SEC   = 60
) (
   input  logic       clk,
   input  logic       alarm_reset,
   input  logic       tick_1hz,
   input  logic       set_btn,
   input  logic       cancel_btn,
   input  logic       stop_btn,
   input  logic       snooze_btn,
   input  logic [0:5] input_data,
   input  logic       alarm_light,
   output logic       ld_alarm_hr,
   output logic       ld_alarm_min,
   output logic       ld_alarm_sec,
   output logic       on_alarm,
   output logic       stop_alarm,
   output logic       armed,
   output logic       entry_err,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SET_HR  = 3'd1;
   localparam logic [2:0] S_SET_MIN = 3'd2;
   localparam logic [2:0] S_SET_SEC = 3'd3;
   localparam logic [2:0] S_ARMED   = 3'd4;
   localparam logic [2:0] S_RINGING = 3'd5;
   localparam logic [2:0] S_SNOOZE  = 3'd6;

   localparam int RING_W = $clog2(RING_SEC);

   logic [2:0]        state_q, state_d;
   logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
   logic              light_prev_q, light_prev_d;
   logic              light_rise;
   logic              field_ok;
   logic              set_req;

`ifdef ALARM_SNOOZE_EN
   localparam int SNZ_W = $clog2(SNOOZE_SEC + 1);
   localparam int MS_W  = $clog2(MAX_SNOOZE + 1);

   logic [SNZ_W-1:0] snz_tmr_q, snz_tmr_d;
   logic [MS_W-1:0]  snooze_cnt_q, snooze_cnt_d;
`endif

   assign light_rise   = alarm_light && !light_prev_q;
   assign light_prev_d = alarm_light;
   // cancel always beats set when both arrive together
   assign set_req      = set_btn && !cancel_btn;
   assign field_ok     = (state_q == S_SET_HR) ? (input_data < 6'd24) : (input_data < 6'd60);

   always_ff @(posedge clk or posedge alarm_reset) begin
      if (alarm_reset) begin
         state_q      <= S_IDLE;
         ring_cnt_q   <= '0;
         light_prev_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_tmr_q    <= '0;
         snooze_cnt_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         light_prev_q <= light_prev_d;
`ifdef ALARM_SNOOZE_EN
         snz_tmr_q    <= snz_tmr_d;
         snooze_cnt_q <= snooze_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snz_tmr_d    = snz_tmr_q;
      snooze_cnt_d = snooze_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (set_req) state_d = S_SET_HR;
         end
         S_SET_HR, S_SET_MIN, S_SET_SEC: begin
            if (cancel_btn)                state_d = S_IDLE;
            else if (set_btn && field_ok)  state_d = state_q + 3'd1;
         end
         S_ARMED: begin
            if (cancel_btn) begin
               state_d = S_IDLE;
            end else if (light_rise) begin
               state_d    = S_RINGING;
               ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
               snooze_cnt_d = '0;
`endif
            end
         end
         S_RINGING: begin
            if (stop_btn) begin
               state_d = S_ARMED;
            end else if (snooze_btn) begin
`ifdef ALARM_SNOOZE_EN
               if (snooze_cnt_q < MS_W'(MAX_SNOOZE)) begin
                  state_d      = S_SNOOZE;
                  snooze_cnt_d = snooze_cnt_q + 1'b1;
                  snz_tmr_d    = '0;
               end else begin
                  state_d = S_ARMED;
               end
`else
               state_d = S_ARMED;
`endif
            end else if (tick_1hz) begin
               if (ring_cnt_q == RING_W'(RING_SEC - 1)) state_d = S_ARMED;
               else                                      ring_cnt_d = ring_cnt_q + 1'b1;
            end
         end
`ifdef ALARM_SNOOZE_EN
         S_SNOOZE: begin
            if (stop_btn || cancel_btn) begin
               state_d = S_ARMED;
            end else if (tick_1hz) begin
               if (snz_tmr_q == SNZ_W'(SNOOZE_SEC - 1)) begin
                  state_d    = S_RINGING;
                  ring_cnt_d = '0;
               end else begin
                  snz_tmr_d = snz_tmr_q + 1'b1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes and error pulses are decoded from the current state and button,
   // so they last exactly the accept/reject cycle.
   always_comb begin
      ld_alarm_hr  = (state_q == S_SET_HR)  && set_req && field_ok;
      ld_alarm_min = (state_q == S_SET_MIN) && set_req && field_ok;
      ld_alarm_sec = (state_q == S_SET_SEC) && set_req && field_ok;
      entry_err    = ((state_q == S_SET_HR) || (state_q == S_SET_MIN) || (state_q == S_SET_SEC))
                     && set_req && !field_ok;
      on_alarm     = (state_q == S_RINGING);
      stop_alarm   = (state_q == S_RINGING) && (state_d != S_RINGING);
      armed        = (state_q == S_ARMED) || (state_q == S_RINGING) || (state_q == S_SNOOZE);
      state_o      = state_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_alarm_set_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_set_controller
//  Purpose  : Scoreboard bench for alarm_set_controller (per-cycle reference
//             model plus directed checks). Follows ALARM_SNOOZE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alarm_set_controller;

`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       alarm_reset = 1'b1;
   logic       tick_1hz = 1'b0, set_btn = 1'b0, cancel_btn = 1'b0;
   logic       stop_btn = 1'b0, snooze_btn = 1'b0, alarm_light = 1'b0;
   logic [0:5] input_data = '0;
   logic       ld_alarm_hr, ld_alarm_min, ld_alarm_sec;
   logic       on_alarm, stop_alarm, armed, entry_err;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_hr = 0, cnt_min = 0, cnt_sec = 0, cnt_err = 0, cnt_stop = 0;

   logic [9:0] exp_q[$];

   // reference model state
   int m_state = 0, m_ring = 0, m_tmr = 0, m_snz = 0;
   bit m_prev = 1'b0;

   alarm_set_controller dut (
      .clk(clk), .alarm_reset(alarm_reset), .tick_1hz(tick_1hz),
      .set_btn(set_btn), .cancel_btn(cancel_btn), .stop_btn(stop_btn),
      .snooze_btn(snooze_btn), .input_data(input_data), .alarm_light(alarm_light),
      .ld_alarm_hr(ld_alarm_hr), .ld_alarm_min(ld_alarm_min), .ld_alarm_sec(ld_alarm_sec),
      .on_alarm(on_alarm), .stop_alarm(stop_alarm), .armed(armed),
      .entry_err(entry_err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] dut_vec();
      return {ld_alarm_hr, ld_alarm_min, ld_alarm_sec, on_alarm, stop_alarm,
              armed, entry_err, state_o};
   endfunction

   // Scoreboard monitor: compares what the model predicted for this cycle.
   always @(negedge clk) begin
      #2;
      if (exp_q.size() != 0) begin
         logic [9:0] e;
         e = exp_q.pop_front();
         chk("cycle_outputs", {22'd0, dut_vec()}, {22'd0, e});
         cnt_hr   += int'(ld_alarm_hr);
         cnt_min  += int'(ld_alarm_min);
         cnt_sec  += int'(ld_alarm_sec);
         cnt_err  += int'(entry_err);
         cnt_stop += int'(stop_alarm);
      end
   end

   task automatic model_eval(output logic [9:0] e);
      int ns;
      bit hr, mn, sc, on, stp, err, rise;
      int lim;
      ns = m_state; hr = 0; mn = 0; sc = 0; on = 0; stp = 0; err = 0;
      rise = alarm_light && !m_prev;
      case (m_state)
         0: if (set_btn && !cancel_btn) ns = 1;
         1, 2, 3: begin
            if (cancel_btn) ns = 0;
            else if (set_btn) begin
               lim = (m_state == 1) ? 24 : 60;
               if (int'(input_data) < lim) begin
                  if (m_state == 1) hr = 1; else if (m_state == 2) mn = 1; else sc = 1;
                  ns = m_state + 1;
               end else err = 1;
            end
         end
         4: begin
            if (cancel_btn) ns = 0;
            else if (rise) begin ns = 5; m_ring = 0; m_snz = 0; end
         end
         5: begin
            on = 1;
            if (stop_btn) ns = 4;
            else if (snooze_btn) begin
               if (SNZ_EN && m_snz < 3) begin ns = 6; m_snz++; m_tmr = 0; end
               else ns = 4;
            end else if (tick_1hz) begin
               m_ring++;
               if (m_ring == 60) ns = 4;
            end
            stp = (ns != 5);
         end
         6: begin
            if (stop_btn || cancel_btn) ns = 4;
            else if (tick_1hz) begin
               m_tmr++;
               if (m_tmr == 300) begin ns = 5; m_ring = 0; end
            end
         end
         default: ns = 0;
      endcase
      e = {hr, mn, sc, on, stp, bit'(m_state >= 4), err, 3'(m_state)};
      m_state = ns;
      m_prev  = alarm_light;
   endtask

   task automatic drive(input bit s, input bit c, input bit st, input bit sz,
                        input bit tk, input int d, input bit lt);
      logic [9:0] e;
      @(negedge clk);
      set_btn = s; cancel_btn = c; stop_btn = st; snooze_btn = sz;
      tick_1hz = tk; input_data = 6'(d); alarm_light = lt;
      model_eval(e);
      exp_q.push_back(e);
      #3;
   endtask

   task automatic idle(input bit lt);
      drive(0, 0, 0, 0, 0, 0, lt);
   endtask

   task automatic ticks(input int n, input bit lt);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 0, lt);
   endtask

   task automatic clr_counts();
      cnt_hr = 0; cnt_min = 0; cnt_sec = 0; cnt_err = 0; cnt_stop = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vec"}, {22'd0, dut_vec()}, 32'd0);
   endtask

   // Mid-cycle asynchronous reset, checked before the next clock edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      set_btn = 1'b1; tick_1hz = 1'b1; input_data = 6'd5;
      #2 alarm_reset = 1'b1;
      #1 check_all_zero(tag);
      chk({tag, "_state"}, {29'd0, state_o}, 32'd0);
      set_btn = 0; cancel_btn = 0; stop_btn = 0; snooze_btn = 0;
      tick_1hz = 0; input_data = '0; alarm_light = 0;
      @(negedge clk);
      alarm_reset = 1'b0;
      m_state = 0; m_ring = 0; m_tmr = 0; m_snz = 0; m_prev = 0;
   endtask

   task automatic enter_time(input int h, input int m, input int s);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, h, 0);
      drive(1, 0, 0, 0, 0, m, 0);
      drive(1, 0, 0, 0, 0, s, 0);
   endtask

   initial begin
      // reset held across edges
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      chk("reset_state", {29'd0, state_o}, 32'd0);
      alarm_reset = 1'b0;

      // 1: enter 07:30:00
      clr_counts();
      enter_time(7, 30, 0);
      idle(0);
      chk("t1_ld_hr_pulses", cnt_hr, 1);
      chk("t1_ld_min_pulses", cnt_min, 1);
      chk("t1_ld_sec_pulses", cnt_sec, 1);
      chk("t1_state", {29'd0, state_o}, 32'd4);
      chk("t1_armed", {31'd0, armed}, 32'd1);

      // 2: range boundaries and cancel priority
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      clr_counts();
      drive(1, 0, 0, 0, 0, 24, 0);
      chk("t2_err_hr24", cnt_err, 1);
      chk("t2_no_ld_hr24", cnt_hr, 0);
      chk("t2_state_stays", {29'd0, state_o}, 32'd1);
      drive(1, 0, 0, 0, 0, 23, 0);
      idle(0);
      chk("t2_ld_hr23", cnt_hr, 1);
      chk("t2_state_min", {29'd0, state_o}, 32'd2);
      drive(1, 1, 0, 0, 0, 10, 0);
      idle(0);
      chk("t2_cancel_wins", {29'd0, state_o}, 32'd0);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 5, 0);
      drive(1, 0, 0, 0, 0, 60, 0);
      drive(1, 0, 0, 0, 0, 59, 0);
      drive(1, 0, 0, 0, 0, 63, 0);
      drive(1, 0, 0, 0, 0, 59, 0);
      idle(0);
      chk("t2_armed_again", {29'd0, state_o}, 32'd4);

      // 3: ring then auto-stop after 60 ticks; light stays high (no retrigger)
      idle(0);
      drive(1, 0, 0, 0, 0, 0, 1);
      idle(1);
      chk("t3_on_alarm", {31'd0, on_alarm}, 32'd1);
      clr_counts();
      ticks(59, 1);
      chk("t3_still_ringing", {29'd0, state_o}, 32'd5);
      ticks(1, 1);
      idle(1);
      idle(1);
      chk("t3_stop_pulses", cnt_stop, 1);
      chk("t3_state_armed", {29'd0, state_o}, 32'd4);
      idle(0);

      // 4: snooze behaviour
      drive(0, 0, 0, 0, 0, 0, 1);
      idle(0);
      clr_counts();
      if (SNZ_EN) begin
         for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            ticks(300, 0);
            idle(0);
            chk("t4_rering", {31'd0, on_alarm}, 32'd1);
         end
         chk("t4_snooze_stops", cnt_stop, 3);
         drive(0, 0, 0, 1, 0, 0, 0);
         idle(0);
         chk("t4_fourth_stops", cnt_stop, 4);
      end else begin
         drive(0, 0, 0, 1, 1, 0, 0);
         idle(0);
         chk("t4_snooze_as_stop", cnt_stop, 1);
      end
      chk("t4_state_armed", {29'd0, state_o}, 32'd4);

      // 5: stop and snooze together
      drive(0, 0, 0, 0, 0, 0, 1);
      idle(0);
      clr_counts();
      drive(0, 0, 1, 1, 0, 0, 0);
      idle(0);
      idle(0);
      chk("t5_stop_once", cnt_stop, 1);
      chk("t5_state_armed", {29'd0, state_o}, 32'd4);

      // 6: async reset in SET_MIN and in RINGING
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 12, 0);
      idle(0);
      async_reset("t6_setmin");
      enter_time(1, 2, 3);
      drive(0, 0, 0, 0, 0, 0, 1);
      ticks(5, 1);
      async_reset("t6_ring");
      idle(0);
      chk("t6_idle_after", {29'd0, state_o}, 32'd0);

      repeat (2) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
